// File: rtl/noc_params.sv
// Shared NoC router parameters: flit type, default buffer geometry and a
// pointer wrap helper used by the virtual-channel input buffer.
package noc_params;

  // Width of one flit as carried on the router datapath.
  localparam int FLIT_W = 16;

  // Default configuration of the per-VC input buffer.
  localparam int DEF_VC_NUM         = 2;
  localparam int DEF_BUFFER_SIZE    = 8;
  localparam int DEF_ON_OFF_LATENCY = 2;

  typedef logic [FLIT_W-1:0] flit_t;

  // Advance a circular pointer; the wrap is an explicit compare so that
  // buffer depths which are not a power of two work correctly.
  function automatic int wrap_inc(input int ptr, input int size);
    if (ptr == size - 1) begin
      return 0;
    end else begin
      return ptr + 1;
    end
  endfunction

endpackage : noc_params

// File: rtl/vc_circular_buffer_lane.sv
// One virtual channel of the input buffer: circular storage, read/write
// pointers, occupancy, registered full/empty flags and on/off flow control.
// push/pop arrive already qualified by the top (push never targets a full
// lane unless pop is also set, pop never targets an empty lane).
module vc_fifo_lane
  import noc_params::*;
#(
  parameter  int BUFFER_SIZE    = DEF_BUFFER_SIZE,
  parameter  int ON_OFF_LATENCY = DEF_ON_OFF_LATENCY,
  localparam int CNT_W          = $clog2(BUFFER_SIZE + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  flit_t            data_i,
  output flit_t            data_o,
  output logic             full,
  output logic             empty,
  output logic             on_off,
  output logic [CNT_W-1:0] num_flits
);

  localparam int PTR_W = (BUFFER_SIZE > 1) ? $clog2(BUFFER_SIZE) : 1;

  // Occupancy thresholds, all in the counter's own width.
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BUFFER_SIZE);
  localparam logic [CNT_W-1:0] OFF_THR  = CNT_W'(BUFFER_SIZE - ON_OFF_LATENCY);
  localparam logic [CNT_W-1:0] ON_THR   = CNT_W'(ON_OFF_LATENCY);

  flit_t            mem_r [BUFFER_SIZE];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             full_r;
  logic             empty_r;
  logic             on_off_r;

  logic [PTR_W-1:0] wr_ptr_nxt_s;
  logic [PTR_W-1:0] rd_ptr_nxt_s;
  logic [CNT_W-1:0] count_nxt_s;
  logic             on_off_nxt_s;

  // Next-state for pointers, occupancy and the on/off hysteresis flag.
  always_comb begin
    wr_ptr_nxt_s = wr_ptr_r;
    rd_ptr_nxt_s = rd_ptr_r;
    count_nxt_s  = count_r;
    on_off_nxt_s = on_off_r;

    if (push) begin
      wr_ptr_nxt_s = PTR_W'(wrap_inc(int'(wr_ptr_r), BUFFER_SIZE));
    end else begin
      wr_ptr_nxt_s = wr_ptr_r;
    end

    if (pop) begin
      rd_ptr_nxt_s = PTR_W'(wrap_inc(int'(rd_ptr_r), BUFFER_SIZE));
    end else begin
      rd_ptr_nxt_s = rd_ptr_r;
    end

    case ({push, pop})
      2'b10:   count_nxt_s = count_r + CNT_ONE;
      2'b01:   count_nxt_s = count_r - CNT_ONE;
      default: count_nxt_s = count_r;
    endcase

    // Stop upstream when the lane is nearly full, release it only once the
    // lane has drained well below that point.
    if (push && !pop && (count_nxt_s > OFF_THR)) begin
      on_off_nxt_s = 1'b0;
    end else if (pop && !push && (count_nxt_s < ON_THR)) begin
      on_off_nxt_s = 1'b1;
    end else begin
      on_off_nxt_s = on_off_r;
    end
  end

  // Control state register; flags are computed from the next occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= PTR_W'(0);
      rd_ptr_r <= PTR_W'(0);
      count_r  <= CNT_ZERO;
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
      on_off_r <= 1'b1;
    end else begin
      wr_ptr_r <= wr_ptr_nxt_s;
      rd_ptr_r <= rd_ptr_nxt_s;
      count_r  <= count_nxt_s;
      full_r   <= (count_nxt_s == CNT_FULL);
      empty_r  <= (count_nxt_s == CNT_ZERO);
      on_off_r <= on_off_nxt_s;
    end
  end

  // Flit storage; deliberately not cleared by reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_r[wr_ptr_r] <= data_i;
    end
  end

  // Show-ahead head flit from the registered read pointer.
  assign data_o    = mem_r[rd_ptr_r];
  assign full      = full_r;
  assign empty     = empty_r;
  assign on_off    = on_off_r;
  assign num_flits = count_r;

endmodule : vc_fifo_lane

// File: rtl/vc_circular_buffer.sv
// Per-virtual-channel input buffer for a router port. A single write port is
// steered to one of VC_NUM circular FIFO lanes by vc_sel_i; every lane has its
// own pop strobe and show-ahead head output.
// Optional error reporting is enabled by defining VC_BUFFER_ERR_CHECK_EN,
// which adds sticky err_overflow_o, err_underflow_o and err_bad_vc_o outputs.
module vc_circular_buffer
  import noc_params::*;
#(
  parameter  int VC_NUM         = DEF_VC_NUM,
  parameter  int BUFFER_SIZE    = DEF_BUFFER_SIZE,
  parameter  int ON_OFF_LATENCY = DEF_ON_OFF_LATENCY,
  localparam int VC_SEL_W       = (VC_NUM > 1) ? $clog2(VC_NUM) : 1,
  localparam int CNT_W          = $clog2(BUFFER_SIZE + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  flit_t                         data_i,
  input  logic                          write_i,
  input  logic [VC_SEL_W-1:0]           vc_sel_i,
  input  logic [VC_NUM-1:0]             read_i,
  output flit_t [VC_NUM-1:0]            data_o,
  output logic  [VC_NUM-1:0]            is_full_o,
  output logic  [VC_NUM-1:0]            is_empty_o,
  output logic  [VC_NUM-1:0]            on_off_o,
`ifdef VC_BUFFER_ERR_CHECK_EN
  output logic  [VC_NUM-1:0]            err_overflow_o,
  output logic  [VC_NUM-1:0]            err_underflow_o,
  output logic                          err_bad_vc_o,
`endif
  output logic  [VC_NUM-1:0][CNT_W-1:0] num_flits_o
);

  logic [VC_NUM-1:0] sel_hit_s;
  logic [VC_NUM-1:0] push_s;
  logic [VC_NUM-1:0] pop_s;

  // Decode the write target and qualify push/pop per lane. A selector beyond
  // the last VC matches no lane, so such writes are dropped.
  always_comb begin
    sel_hit_s = '0;
    push_s    = '0;
    pop_s     = '0;
    for (int v = 0; v < VC_NUM; v++) begin
      sel_hit_s[v] = write_i && (int'(vc_sel_i) == v);
      pop_s[v]     = read_i[v] && !is_empty_o[v];
      push_s[v]    = sel_hit_s[v] && (!is_full_o[v] || pop_s[v]);
    end
  end

  for (genvar v = 0; v < VC_NUM; v++) begin : gen_lane
    vc_fifo_lane #(
      .BUFFER_SIZE   (BUFFER_SIZE),
      .ON_OFF_LATENCY(ON_OFF_LATENCY)
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .push     (push_s[v]),
      .pop      (pop_s[v]),
      .data_i   (data_i),
      .data_o   (data_o[v]),
      .full     (is_full_o[v]),
      .empty    (is_empty_o[v]),
      .on_off   (on_off_o[v]),
      .num_flits(num_flits_o[v])
    );
  end

`ifdef VC_BUFFER_ERR_CHECK_EN
  logic bad_vc_s;

  // Flag a write whose selector addresses no existing VC.
  always_comb begin
    bad_vc_s = write_i && (int'(vc_sel_i) >= VC_NUM);
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_overflow_o  <= '0;
      err_underflow_o <= '0;
      err_bad_vc_o    <= 1'b0;
    end else begin
      err_overflow_o  <= err_overflow_o  | (sel_hit_s & is_full_o & ~pop_s);
      err_underflow_o <= err_underflow_o | (read_i & is_empty_o);
      err_bad_vc_o    <= err_bad_vc_o | bad_vc_s;
    end
  end
`endif

endmodule : vc_circular_buffer

// File: tb/tb_vc_circular_buffer.sv
// Self-checking bench for vc_circular_buffer (VC_NUM=2, BUFFER_SIZE=4,
// ON_OFF_LATENCY=2): directed scenarios followed by random traffic, all
// compared against a queue-based reference model.
module tb_vc_circular_buffer;
  import noc_params::*;

  localparam int VC_NUM   = 2;
  localparam int BS       = 4;
  localparam int OOL      = 2;
  localparam int VC_SEL_W = 1;
  localparam int CNT_W    = 3;

  logic                          clk;
  logic                          rst;
  flit_t                         data_i;
  logic                          write_i;
  logic [VC_SEL_W-1:0]           vc_sel_i;
  logic [VC_NUM-1:0]             read_i;
  flit_t [VC_NUM-1:0]            data_o;
  logic  [VC_NUM-1:0]            is_full_o;
  logic  [VC_NUM-1:0]            is_empty_o;
  logic  [VC_NUM-1:0]            on_off_o;
  logic  [VC_NUM-1:0][CNT_W-1:0] num_flits_o;
`ifdef VC_BUFFER_ERR_CHECK_EN
  logic  [VC_NUM-1:0]            err_overflow_o;
  logic  [VC_NUM-1:0]            err_underflow_o;
  logic                          err_bad_vc_o;
`endif

  vc_circular_buffer #(
    .VC_NUM        (VC_NUM),
    .BUFFER_SIZE   (BS),
    .ON_OFF_LATENCY(OOL)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .data_i         (data_i),
    .write_i        (write_i),
    .vc_sel_i       (vc_sel_i),
    .read_i         (read_i),
    .data_o         (data_o),
    .is_full_o      (is_full_o),
    .is_empty_o     (is_empty_o),
    .on_off_o       (on_off_o),
`ifdef VC_BUFFER_ERR_CHECK_EN
    .err_overflow_o (err_overflow_o),
    .err_underflow_o(err_underflow_o),
    .err_bad_vc_o   (err_bad_vc_o),
`endif
    .num_flits_o    (num_flits_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: one queue of flits per VC plus the flow-control bit.
  flit_t q [VC_NUM][$];
  bit    m_on [VC_NUM];
  bit    m_ovf [VC_NUM];
  bit    m_udf [VC_NUM];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Compare every observable output with the model.
  task automatic check_all();
    for (int v = 0; v < VC_NUM; v++) begin
      check($sformatf("empty[%0d]", v), 32'(is_empty_o[v]), 32'(q[v].size() == 0));
      check($sformatf("full[%0d]", v),  32'(is_full_o[v]),  32'(q[v].size() == BS));
      check($sformatf("count[%0d]", v), 32'(num_flits_o[v]), 32'(q[v].size()));
      check($sformatf("on_off[%0d]", v), 32'(on_off_o[v]), 32'(m_on[v]));
      if (q[v].size() > 0) begin
        check($sformatf("head[%0d]", v), 32'(data_o[v]), 32'(q[v][0]));
      end
`ifdef VC_BUFFER_ERR_CHECK_EN
      check($sformatf("err_ovf[%0d]", v), 32'(err_overflow_o[v]), 32'(m_ovf[v]));
      check($sformatf("err_udf[%0d]", v), 32'(err_underflow_o[v]), 32'(m_udf[v]));
`endif
    end
`ifdef VC_BUFFER_ERR_CHECK_EN
    check("err_bad_vc", 32'(err_bad_vc_o), 32'd0);
`endif
  endtask

  // Reset, optionally with a write strobe held to show reset wins.
  task automatic do_reset(input bit wr);
    rst      = 1'b1;
    write_i  = wr;
    vc_sel_i = '0;
    data_i   = 16'hDEAD;
    read_i   = 2'b11;
    @(posedge clk); #1;
    rst     = 1'b0;
    write_i = 1'b0;
    read_i  = '0;
    for (int v = 0; v < VC_NUM; v++) begin
      q[v].delete();
      m_on[v]  = 1'b1;
      m_ovf[v] = 1'b0;
      m_udf[v] = 1'b0;
    end
    check_all();
  endtask

  // One clock of stimulus; the model is advanced from the spec rules.
  task automatic cycle(input bit wr, input int sel, input flit_t d, input logic [1:0] rd);
    bit acc_rd [VC_NUM];
    bit acc_wr [VC_NUM];
    int old_n;
    int new_n;
    write_i  = wr;
    vc_sel_i = VC_SEL_W'(sel);
    data_i   = d;
    read_i   = rd;
    for (int v = 0; v < VC_NUM; v++) begin
      acc_rd[v] = rd[v] && (q[v].size() > 0);
      acc_wr[v] = wr && (sel == v) && ((q[v].size() < BS) || acc_rd[v]);
      if (wr && (sel == v) && (q[v].size() == BS) && !acc_rd[v]) m_ovf[v] = 1'b1;
      if (rd[v] && (q[v].size() == 0)) m_udf[v] = 1'b1;
    end
    @(posedge clk); #1;
    for (int v = 0; v < VC_NUM; v++) begin
      old_n = q[v].size();
      if (acc_rd[v]) void'(q[v].pop_front());
      if (acc_wr[v]) q[v].push_back(d);
      new_n = q[v].size();
      if ((new_n > old_n) && (new_n > BS - OOL)) m_on[v] = 1'b0;
      else if ((new_n < old_n) && (new_n < OOL)) m_on[v] = 1'b1;
    end
    write_i = 1'b0;
    read_i  = '0;
    check_all();
  endtask

  initial begin
    rst      = 1'b1;
    write_i  = 1'b0;
    vc_sel_i = '0;
    data_i   = '0;
    read_i   = '0;

    // Reset and idle.
    do_reset(1'b0);
    check("rst_empty", 32'(is_empty_o), 32'd3);
    check("rst_onoff", 32'(on_off_o), 32'd3);
    cycle(1'b0, 0, 16'h0, 2'b00);

    // Fill VC0 with A..D, then an overflow attempt with E.
    cycle(1'b1, 0, 16'h000A, 2'b00);
    cycle(1'b1, 0, 16'h000B, 2'b00);
    check("onoff_after2", 32'(on_off_o[0]), 32'd1);
    cycle(1'b1, 0, 16'h000C, 2'b00);
    check("onoff_after3", 32'(on_off_o[0]), 32'd0);
    cycle(1'b1, 0, 16'h000D, 2'b00);
    check("full_after4", 32'(is_full_o[0]), 32'd1);
    check("count_after4", 32'(num_flits_o[0]), 32'd4);
    cycle(1'b1, 0, 16'h000E, 2'b00);
    check("count_after_E", 32'(num_flits_o[0]), 32'd4);
    check("vc1_empty", 32'(is_empty_o[1]), 32'd1);

    // Drain VC0 in order.
    check("pop_A", 32'(data_o[0]), 32'h000A);
    cycle(1'b0, 0, 16'h0, 2'b01);
    check("pop_B", 32'(data_o[0]), 32'h000B);
    cycle(1'b0, 0, 16'h0, 2'b01);
    check("pop_C", 32'(data_o[0]), 32'h000C);
    check("onoff_cnt2", 32'(on_off_o[0]), 32'd0);
    cycle(1'b0, 0, 16'h0, 2'b01);
    check("pop_D", 32'(data_o[0]), 32'h000D);
    check("onoff_cnt1", 32'(on_off_o[0]), 32'd1);
    cycle(1'b0, 0, 16'h0, 2'b01);
    check("empty_after4", 32'(is_empty_o[0]), 32'd1);

    // Refill, then write F and read together while full.
    for (int i = 0; i < 4; i++) cycle(1'b1, 0, flit_t'(16'h00A1 + i), 2'b00);
    cycle(1'b1, 0, 16'h000F, 2'b01);
    check("wr_rd_full_count", 32'(num_flits_o[0]), 32'd4);
    check("wr_rd_full_flag", 32'(is_full_o[0]), 32'd1);
    check("wr_rd_full_head", 32'(data_o[0]), 32'h00A2);

    // Read plus write on empty VC1: read ignored, G stored.
    cycle(1'b1, 1, 16'h0006, 2'b10);
    check("vc1_g_count", 32'(num_flits_o[1]), 32'd1);
    check("vc1_g_head", 32'(data_o[1]), 32'h0006);

    // Write VC1 while popping VC0.
    cycle(1'b1, 1, 16'h0106, 2'b01);
    cycle(1'b1, 1, 16'h0107, 2'b01);

    // Write/read pairs on VC1 to exercise the pointer wrap.
    for (int i = 0; i < 10; i++) cycle(1'b1, 1, flit_t'(16'h0200 + i), 2'b10);

    // Reset in the middle of a fill with a write strobe asserted.
    cycle(1'b1, 0, 16'h0301, 2'b00);
    do_reset(1'b1);
    check("midrst_count0", 32'(num_flits_o[0]), 32'd0);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      cycle(bit'($urandom_range(0, 3) != 0), int'($urandom_range(0, VC_NUM - 1)),
            flit_t'($urandom), 2'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_vc_circular_buffer

// File: doc/vc_circular_buffer.md
Name: vc_circular_buffer

Overview:
- Per-virtual-channel flit buffer for a router input port; successor to the single-queue input buffer.
- Holds VC_NUM independent circular FIFOs of BUFFER_SIZE flits each, with shared write port (flit steered by VC id) and independent per-VC read ports.
- Provides per-VC full/empty/occupancy and on/off flow-control flags to the upstream link and to the VC allocator/switch allocator.

Parameters:
- VC_NUM, 2, number of virtual channels (>=1).
- BUFFER_SIZE, 8, flits per VC (>=2, need not be a power of two).
- ON_OFF_LATENCY, 2, on/off hysteresis margin in flits (1 <= ON_OFF_LATENCY <= BUFFER_SIZE/2).

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- data_i  input  flit_t  flit to store.
- write_i  input  1  write strobe for data_i.
- vc_sel_i  input  VC_SEL_W  target VC of the write (VC_SEL_W = max(1,$clog2(VC_NUM))).
- read_i  input  VC_NUM  per-VC pop strobe.
- data_o  output  VC_NUM x flit_t  head flit of each VC (show-ahead).
- is_full_o  output  VC_NUM  per-VC full flag.
- is_empty_o  output  VC_NUM  per-VC empty flag.
- on_off_o  output  VC_NUM  per-VC flow-control: 1 = upstream may send.
- num_flits_o  output  VC_NUM x CNT_W  per-VC occupancy (CNT_W = $clog2(BUFFER_SIZE+1)).

Behaviour:
- Single clock domain; reset synchronous active-high on clk, as already decided. All state updates on posedge clk.
- Reset (takes priority over any strobe, also mid-operation): pointers=0, num_flits_o=0, is_empty_o=all 1, is_full_o=all 0, on_off_o=all 1. Memory is not cleared; data_o is don't-care while empty.
- Write to VC v (v=vc_sel_i) is accepted when write_i & (v<VC_NUM) & (~is_full_o[v] | (read_i[v] & ~is_empty_o[v])).
- Read of VC v is accepted when read_i[v] & ~is_empty_o[v]. A read on an empty VC is ignored, even with a simultaneous write to it.
- Per VC, per cycle:
  - read only: rd_ptr advances; count -1.
  - write only: wr_ptr advances; count +1.
  - both: both pointers advance; count unchanged; full/empty unchanged.
  - neither: state held.
- Pointer wrap: BUFFER_SIZE-1 -> 0 by explicit compare, not by modulo-2^n.
- Flags are registered and derived from next count: empty = (count_next==0), full = (count_next==BUFFER_SIZE). Zero-cycle bypass: none. A written flit appears on data_o the cycle after the write.
- data_o[v] = mem[v][rd_ptr[v]], combinational from registered pointers.
- On/off, per VC, registered:
  - falls to 0 when count increases and count_next > BUFFER_SIZE-ON_OFF_LATENCY.
  - rises to 1 when count decreases and count_next < ON_OFF_LATENCY.
  - otherwise held.
- Writes to VC v never affect any other VC. Any number of VCs may be read in the same cycle.
- vc_sel_i >= VC_NUM (non-power-of-two VC_NUM): write dropped.

Optional Feature:
- Macro VC_BUFFER_ERR_CHECK_EN.
- Defined: adds outputs err_overflow_o[VC_NUM] and err_underflow_o[VC_NUM], both sticky and cleared only by rst.
  - err_overflow_o[v] sets on a write to full VC v without an accepted read.
  - err_underflow_o[v] sets on read_i[v] while VC v is empty.
  - Also adds a global err_bad_vc_o, set on write_i with vc_sel_i >= VC_NUM.
  - Datapath is unchanged.
- Undefined: these ports do not exist; illegal operations are silently ignored as above.

Decomposition:
- noc_params package holds flit_t plus VC_NUM, BUFFER_SIZE and ON_OFF_LATENCY defaults.
- Derived widths (VC_SEL_W, CNT_W) are localparams in the block.
- Sub-module vc_fifo_lane: one VC's storage, pointers, count, flags and on/off. It has inputs push/pop pre-qualified by the top.
- Top decodes vc_sel_i, generates VC_NUM lanes, and collects error flags.

Test Plan (VC_NUM=2, BUFFER_SIZE=4, ON_OFF_LATENCY=2):
- Reset, then idle -> is_empty_o=2'b11, is_full_o=0, on_off_o=2'b11, num_flits_o=0. Assert rst mid-fill: next cycle same values.
- Write A,B,C,D to VC0 on consecutive cycles:
  - after the 3rd write, on_off_o[0]=0;
  - after the 4th, is_full_o[0]=1, num_flits_o[0]=4;
  - 5th write E -> dropped (err_overflow_o[0]=1 if enabled).
  - VC1 stays empty throughout.
- Pop VC0 four times -> data_o[0] = A,B,C,D in order.
  - on_off_o[0] returns to 1 after count falls to 1.
  - is_empty_o[0]=1 after the 4th pop.
- VC0 full, simultaneous write F and read -> data_o[0] advances, F stored at the wrapped slot, count stays 4, is_full_o[0] stays 1.
- VC1 empty, read_i[1] and write G to VC1 same cycle -> read ignored, count=1, data_o[1]=G next cycle (err_underflow_o[1]=1 if enabled).
- Interleave: write VC1 while popping VC0 in the same cycle -> both counts update independently; 10 write/read pairs on VC1 -> wrap-around keeps FIFO order.
